// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage of the MIPS pipeline. Owns the
//               program counter, drives chip-enable and byte address into a
//               combinational instruction ROM, and captures the returned
//               word together with its PC into the IF/ID pipeline register.
//               Handles stalls, delayed-branch redirects (including branches
//               that arrive while the PC is stalled) and exception flushes.
//
// Ports       : clk, rst          - clock (rising edge), async active-high reset
//               stall_if          - hold the PC this cycle
//               stall_id          - hold IF/ID this cycle (implies stall_if)
//               branch_flag_i     - taken branch/jump pulse from decode
//               branch_target_i   - branch destination
//               flush_i           - exception/eret flush pulse
//               flush_pc_i        - handler/return address on flush
//               rom_ce_o          - ROM chip enable (registered)
//               rom_addr_o        - ROM byte address (current PC)
//               rom_inst_i        - ROM data, same cycle as rom_addr_o
//               id_pc_o           - PC of the instruction held in IF/ID
//               id_inst_o         - instruction held in IF/ID (0 when invalid)
//               id_valid_o        - IF/ID holds a real instruction
//               id_misalign_o     - IF/ID instruction came from a misaligned
//                                   redirect target
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int                           INST_ADDR_WIDTH = 32,
    parameter int                           INST_DATA_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0]   RESET_PC        = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_if,
    input  logic                        stall_id,
    input  logic                        branch_flag_i,
    input  logic [INST_ADDR_WIDTH-1:0]  branch_target_i,
    input  logic                        flush_i,
    input  logic [INST_ADDR_WIDTH-1:0]  flush_pc_i,
    output logic                        rom_ce_o,
    output logic [INST_ADDR_WIDTH-1:0]  rom_addr_o,
    input  logic [INST_DATA_WIDTH-1:0]  rom_inst_i,
    output logic [INST_ADDR_WIDTH-1:0]  id_pc_o,
    output logic [INST_DATA_WIDTH-1:0]  id_inst_o,
    output logic                        id_valid_o,
    output logic                        id_misalign_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                      c_AW      = INST_ADDR_WIDTH;
    localparam logic [c_AW-1:0]         c_PC_STEP = c_AW'(4);

    // Fetch FSM encoding
    localparam logic [0:0]              c_BOOT    = 1'b0;
    localparam logic [0:0]              c_RUN     = 1'b1;

    // Word-align an address by dropping the byte offset.
    function automatic logic [c_AW-1:0] f_align(input logic [c_AW-1:0] addr);
        return {addr[c_AW-1:2], 2'b00};
    endfunction

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               r_rom_ce;
    logic               w_rom_ce_next;
    logic               w_run;

    logic [c_AW-1:0]    r_pc;
    logic [c_AW-1:0]    w_pc_next;
    logic               r_pend_valid;
    logic               w_pend_valid_next;
    logic [c_AW-1:0]    r_pend_target;
    logic [c_AW-1:0]    w_pend_target_next;
    logic               r_misalign;
    logic               w_misalign_next;

    logic               w_stall;
    logic               w_redirect;
    logic [c_AW-1:0]    w_redirect_target;

    logic [c_AW-1:0]            r_id_pc;
    logic [INST_DATA_WIDTH-1:0] r_id_inst;
    logic                       r_id_valid;
    logic                       r_id_misalign;

    // The flush address always comes from the exception unit, which only
    // produces word addresses; its byte offset is simply discarded.
    logic               w_unused_flush_lsb;
    assign w_unused_flush_lsb = ^flush_pc_i[1:0];

    // A decode stall must also freeze the PC, otherwise the fetch that is
    // being held in IF/ID would be skipped.
    assign w_stall = stall_if | stall_id;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_BOOT;
            r_rom_ce <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rom_ce <= w_rom_ce_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // BOOT lasts exactly one edge after reset release; RUN is terminal.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_BOOT:  w_state_next = c_RUN;
            c_RUN:   w_state_next = c_RUN;
            default: w_state_next = c_BOOT;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // Chip enable is computed from the next state so that it comes straight
    // out of a flop and is high for the whole first RUN cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rom_ce_next = (w_state_next == c_RUN);
        w_run         = (r_state == c_RUN);
    end

    // ------------------------------------------------------------------------
    // PC next-value selection
    // Priority: flush > stall (remember branch) > pending branch > branch >
    // sequential. A branch seen while stalled is parked in the pending
    // register and replayed on the first unstalled edge, so it is not lost.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_next          = r_pc;
        w_pend_valid_next  = r_pend_valid;
        w_pend_target_next = r_pend_target;
        w_misalign_next    = r_misalign;
        w_redirect         = 1'b0;
        w_redirect_target  = r_pend_target;

        if (flush_i) begin
            // Flush is honoured even in BOOT; it discards any parked branch.
            w_pc_next         = f_align(flush_pc_i);
            w_pend_valid_next = 1'b0;
            w_misalign_next   = 1'b0;
        end else if (w_run) begin
            if (w_stall) begin
                if (branch_flag_i) begin
                    w_pend_valid_next  = 1'b1;
                    w_pend_target_next = branch_target_i;
                end
            end else begin
                if (r_pend_valid) begin
                    w_redirect        = 1'b1;
                    w_redirect_target = r_pend_target;
                    w_pend_valid_next = 1'b0;
                end else if (branch_flag_i) begin
                    w_redirect        = 1'b1;
                    w_redirect_target = branch_target_i;
                end

                // The flag follows the fetch it describes: it is rebuilt
                // every time the PC moves on, i.e. when the previous fetch
                // is being captured into IF/ID.
                if (w_redirect) begin
                    w_pc_next       = f_align(w_redirect_target);
                    w_misalign_next = |w_redirect_target[1:0];
                end else begin
                    w_pc_next       = r_pc + c_PC_STEP;
                    w_misalign_next = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // PC, pending-branch and misalign registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= f_align(RESET_PC);
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_pend_valid  <= w_pend_valid_next;
            r_pend_target <= w_pend_target_next;
            r_misalign    <= w_misalign_next;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID pipeline register
    // Branches never squash this register: the word fetched while a branch
    // is in decode is its delay slot and is captured like any other.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_pc       <= '0;
            r_id_inst     <= '0;
            r_id_valid    <= 1'b0;
            r_id_misalign <= 1'b0;
        end else if (flush_i) begin
            r_id_pc       <= '0;
            r_id_inst     <= '0;
            r_id_valid    <= 1'b0;
            r_id_misalign <= 1'b0;
        end else if (stall_id) begin
            r_id_pc       <= r_id_pc;
            r_id_inst     <= r_id_inst;
            r_id_valid    <= r_id_valid;
            r_id_misalign <= r_id_misalign;
        end else if (stall_if || !w_run) begin
            // Bubble: nothing was fetched on the BOOT edge, and a stalled
            // fetch will be presented again next cycle.
            r_id_pc       <= '0;
            r_id_inst     <= '0;
            r_id_valid    <= 1'b0;
            r_id_misalign <= 1'b0;
        end else begin
            r_id_pc       <= r_pc;
            r_id_inst     <= rom_inst_i;
            r_id_valid    <= r_rom_ce;
            r_id_misalign <= r_misalign;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_ce_o      = r_rom_ce;
    assign rom_addr_o    = r_pc;
    assign id_pc_o       = r_id_pc;
    assign id_inst_o     = r_id_inst;
    assign id_valid_o    = r_id_valid;
    assign id_misalign_o = r_id_misalign;

endmodule
`default_nettype wire
